// File: rtl/layernorm_inv_sqrt_if.sv
// Handshake and data bundle between the LayerNorm statistics stage,
// the inverse-sqrt block and layernorm_postprocess.
interface layernorm_inv_sqrt_if;
    logic         valid_in;
    logic         in_ready;
    logic [15:0]  variance_in;
    logic [15:0]  mean_in;
    logic [255:0] diff_vector_in;
    logic         valid_out;
    logic [15:0]  inv_sigma_out;
    logic [15:0]  mean_out;
    logic [255:0] diff_vector_out;

    // Upstream / test side: drives the request, observes the result.
    modport master (
        output valid_in, variance_in, mean_in, diff_vector_in,
        input  in_ready, valid_out, inv_sigma_out, mean_out, diff_vector_out
    );

    // Block side: consumes the request, produces the result.
    modport slave (
        input  valid_in, variance_in, mean_in, diff_vector_in,
        output in_ready, valid_out, inv_sigma_out, mean_out, diff_vector_out
    );
endinterface

// File: rtl/layernorm_inv_sqrt.sv
// inv_sigma = 1/sqrt(variance + EPS) in Q5.10 by an iterative
// Newton-Raphson FSM (SQ -> MUL -> UPD per iteration). Mean and the diff
// vector are captured at accept and forwarded with the result.
module layernorm_inv_sqrt #(
    parameter logic [15:0] EPS   = 16'd1,
    parameter int          ITERS = 3
) (
    input logic                 clk,
    input logic                 rst,
    layernorm_inv_sqrt_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_SQ   = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]   r_state;
    logic [2:0]   r_iter;
    logic [15:0]  r_x;
    logic [15:0]  r_y;
    logic [31:0]  r_sq;
    logic [31:0]  r_t;
    logic [15:0]  r_mean;
    logic [255:0] r_diff;
    logic         r_valid_out;
    logic [15:0]  r_inv_sigma;
    logic [15:0]  r_mean_out;
    logic [255:0] r_diff_out;

    logic [15:0]         w_var_pos;
    logic [16:0]         w_x_sum;
    logic [15:0]         w_x_in;
    logic [3:0]          w_p;
    logic [3:0]          w_s;
    logic [10:0]         w_k;
    logic [31:0]         w_seed;
    logic [15:0]         w_y_seed;
    logic [47:0]         w_prod;
    logic signed [31:0]  w_h;
    logic signed [47:0]  w_yh;
    logic [15:0]         w_y_upd;
    logic                w_last_iter;

    // Input conditioning: clamp negative variance to 0, add EPS, saturate.
    always_comb begin
        w_var_pos = bus.variance_in[15] ? 16'd0 : bus.variance_in;
        w_x_sum   = {1'b0, w_var_pos} + {1'b0, EPS};
        w_x_in    = (w_x_sum > 17'h07FFF) ? 16'h7FFF : w_x_sum[15:0];
    end

    // Seed from the leading-one position of x. The power-of-two estimate
    // 2^(10+floor((10-p)/2)) is scaled by 2^-0.25 (even p) or 2^+0.25
    // (odd p) so that seed/true always lies in [0.84, 1.19]; that keeps
    // the residual error after the last iteration well below one LSB.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        w_p = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (r_x[i]) w_p = 4'(i);
        end
        w_s      = 4'((5'd30 - {1'b0, w_p}) >> 1);
        w_k      = w_p[0] ? 11'd1218 : 11'd861;
        w_seed   = (32'(w_k) << w_s) >> 10;
        w_y_seed = (w_seed > 32'h0000_7FFF) ? 16'h7FFF : w_seed[15:0];
    end

    // One Newton step y' = y*(3 - x*y^2)/2, in Q.10 with the /2 folded
    // into the >>>11.
    always_comb begin
        w_prod = 48'(r_x) * 48'(r_sq);
        w_h    = 32'sd3072 - $signed(r_t);
        w_yh   = ($signed({32'd0, r_y}) * $signed({{16{w_h[31]}}, w_h})) >>> 11;
        if (w_yh < 48'sd0) begin
            w_y_upd = 16'h0000;
        end else if (w_yh > 48'sh7FFF) begin
            w_y_upd = 16'h7FFF;
        end else begin
            w_y_upd = w_yh[15:0];
        end
        w_last_iter = (int'(r_iter) + 1 >= ITERS);
    end

    // Control FSM and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= 3'd0;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
            r_sq    <= 32'd0;
            r_t     <= 32'd0;
            r_mean  <= 16'd0;
            // NOTE: the diff capture is a flop bank, not a RAM, so it takes
            // the reset like the rest; a stale vector can never leak out.
            r_diff  <= 256'd0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples
            // the pre-edge value of its sources, independent of order.
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        r_x     <= w_x_in;
                        r_mean  <= bus.mean_in;
                        r_diff  <= bus.diff_vector_in;
                        r_state <= S_SEED;
                    end
                end
                S_SEED: begin
                    r_y     <= w_y_seed;
                    r_iter  <= 3'd0;
                    r_state <= S_SQ;
                end
                S_SQ: begin
                    r_sq    <= 32'(r_y) * 32'(r_y);
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_t     <= 32'(w_prod >> 20);
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    r_y     <= w_y_upd;
                    r_iter  <= r_iter + 3'd1;
                    r_state <= w_last_iter ? S_OUT : S_SQ;
                end
                S_OUT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result registers: loaded once per operation, held between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_inv_sigma <= 16'd0;
            r_mean_out  <= 16'd0;
            r_diff_out  <= 256'd0;
        end else begin
            r_valid_out <= (r_state == S_OUT);
            if (r_state == S_OUT) begin
                r_inv_sigma <= r_y;
                r_mean_out  <= r_mean;
                r_diff_out  <= r_diff;
            end
        end
    end

    assign bus.in_ready        = (r_state == S_IDLE);
    assign bus.valid_out       = r_valid_out;
    assign bus.inv_sigma_out   = r_inv_sigma;
    assign bus.mean_out        = r_mean_out;
    assign bus.diff_vector_out = r_diff_out;

endmodule
